// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: line, strobe and host-handshake bundle for uart_rx_ctrl
//   master (host/datapath side) drives ena, rx, frame_ack
//   slave  (uart_rx_ctrl) drives rx_bit, shift_en, bit_idx, busy,
//          frame_valid, frame_err, overrun
interface uart_rx_ctrl_if;
  logic       ena;
  logic       rx;
  logic       frame_ack;
  logic       rx_bit;
  logic       shift_en;
  logic [2:0] bit_idx;
  logic       busy;
  logic       frame_valid;
  logic       frame_err;
  logic       overrun;
  modport master (
    output ena, rx, frame_ack,
    input  rx_bit, shift_en, bit_idx, busy, frame_valid, frame_err, overrun
  );
  modport slave (
    input  ena, rx, frame_ack,
    output rx_bit, shift_en, bit_idx, busy, frame_valid, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive bit-timing controller and frame sequencer
//   clk, rst_n (async, active-low)
//   bus.ena/rx/frame_ack in; bus.rx_bit/shift_en/bit_idx/busy/frame_valid/
//   frame_err/overrun out
//   Define UART_RX_MAJORITY_EN to vote each decision over the last three ticks.
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_ctrl_if.slave bus
);
  localparam int DW  = $clog2(CLK_DIV);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         r_state;
  logic [1:0]     r_sync;
  logic [DW-1:0]  r_div_cnt;
  logic [OSW-1:0] r_os_cnt;
  logic [2:0]     r_bit_idx;
  logic           r_rx_bit;
  logic           r_shift_en;
  logic           r_frame_valid;
  logic           r_frame_err;
  logic           r_overrun;
  logic           w_tick;
  logic           w_rx_s;
  logic           w_sample;
  assign w_rx_s = r_sync[1];
  assign w_tick = bus.ena && r_div_cnt == DIV_LAST;
`ifdef UART_RX_MAJORITY_EN
  // rx_s captured on the two ticks preceding the current one
  logic [1:0] r_vote;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vote <= 2'b11;
    else if (w_tick) r_vote <= {r_vote[0], w_rx_s};
  assign w_sample = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rx_s) | (r_vote[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync        <= 2'b11;
      r_div_cnt     <= '0;
      r_os_cnt      <= '0;
      r_state       <= IDLE;
      r_bit_idx     <= '0;
      r_rx_bit      <= 1'b1;
      r_shift_en    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], bus.rx};
      r_shift_en  <= 1'b0;
      r_frame_err <= 1'b0;
      if (bus.frame_ack) begin
        r_frame_valid <= 1'b0;
        r_overrun     <= 1'b0;
      end
      if (!bus.ena) begin
        r_state   <= IDLE;
        r_div_cnt <= '0;
        r_os_cnt  <= '0;
        r_bit_idx <= '0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        if (w_tick) begin
          case (r_state)
            IDLE: if (!w_rx_s) begin
              r_state  <= START;
              r_os_cnt <= '0;
            end
            START: if (r_os_cnt == OS_HALF) begin
              r_os_cnt  <= '0;
              r_bit_idx <= '0;
              r_state   <= w_sample ? IDLE : DATA;
            end else r_os_cnt <= r_os_cnt + 1'b1;
            DATA: if (r_os_cnt == OS_LAST) begin
              r_os_cnt   <= '0;
              r_shift_en <= 1'b1;
              r_rx_bit   <= w_sample;
              if (r_bit_idx == BIT_LAST) r_state <= STOP;
              else r_bit_idx <= r_bit_idx + 1'b1;
            end else r_os_cnt <= r_os_cnt + 1'b1;
            STOP: if (r_os_cnt == OS_LAST) begin
              r_os_cnt  <= '0;
              r_bit_idx <= '0;
              r_state   <= IDLE;
              if (w_sample) begin
                // a frame landing in the same clk as an ack replaces the acked one cleanly
                r_frame_valid <= 1'b1;
                if (r_frame_valid && !bus.frame_ack) r_overrun <= 1'b1;
              end else r_frame_err <= 1'b1;
            end else r_os_cnt <= r_os_cnt + 1'b1;
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end
  assign bus.rx_bit      = r_rx_bit;
  assign bus.shift_en    = r_shift_en;
  assign bus.bit_idx     = r_bit_idx;
  assign bus.busy        = r_state != IDLE;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.overrun     = r_overrun;
endmodule
